// File: rtl/pipe_stage_reg_if.sv
// Handshake and payload bundle between a pipeline stage register and its
// neighbours. The slave side belongs to the stage register itself; the
// master side belongs to whatever drives and consumes it.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 256,
  parameter int PC_W   = 32,
  parameter int TN_W   = 2,
  parameter int EXC_W  = 5
) ();

  // Upstream (entry offered to the stage)
  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic              in_bd;
  logic [EXC_W-1:0]  in_exc;
  logic [TN_W-1:0]   in_tnew;
  logic [DATA_W-1:0] in_data;

  // Downstream (head entry presented by the stage)
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic              out_bd;
  logic [EXC_W-1:0]  out_exc;
  logic [TN_W-1:0]   out_tnew;
  logic [DATA_W-1:0] out_data;
  logic              out_bubble;

  modport master (
    output in_valid, in_pc, in_bd, in_exc, in_tnew, in_data, out_ready,
    input  in_ready, out_valid, out_pc, out_bd, out_exc, out_tnew,
           out_data, out_bubble
  );

  modport slave (
    input  in_valid, in_pc, in_bd, in_exc, in_tnew, in_data, out_ready,
    output in_ready, out_valid, out_pc, out_bd, out_exc, out_tnew,
           out_data, out_bubble
  );

endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register built as a 2-entry skid buffer. Entries carry PC,
// branch-delay flag, exception code, Tnew countdown, payload and a bubble
// flag. A hazard stall (kill) turns the accepted entry into a bubble; an
// exception request (req) flushes everything and injects a bubble at the
// exception vector; reset injects a bubble at the reset vector.
module pipe_stage_reg #(
  parameter int              DATA_W   = 256,
  parameter int              PC_W     = 32,
  parameter int              TN_W     = 2,
  parameter int              EXC_W    = 5,
  parameter logic [PC_W-1:0] RESET_PC = 32'h3000,
  parameter logic [PC_W-1:0] EXC_PC   = 32'h4180
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  kill,
  pipe_stage_reg_if.slave       bus,
  output logic [1:0]            occupancy
);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic              bd;
    logic [EXC_W-1:0]  exc;
    logic [TN_W-1:0]   tnew;
    logic [DATA_W-1:0] data;
    logic              bubble;
  } entry_t;

  // Bubble entry parked at a given PC; used for reset and exception entry.
  function automatic entry_t bubble_at(input logic [PC_W-1:0] pc);
    entry_t e;
    e        = '0;
    e.pc     = pc;
    e.bubble = 1'b1;
    return e;
  endfunction

  entry_t     head_q, head_d;   // entry presented on out_*
  entry_t     skid_q, skid_d;   // second entry, valid only at occupancy 2
  logic [1:0] occ_q,  occ_d;
  entry_t     in_entry;
  logic       push, pop;

  // Ready and valid come purely from registered occupancy, so there is no
  // combinational path from out_ready back to in_ready.
  assign bus.in_ready  = (occ_q < 2'd2);
  assign bus.out_valid = (occ_q != 2'd0);
  assign occupancy     = occ_q;

  assign push = bus.in_valid  & bus.in_ready  & ~req;
  assign pop  = bus.out_valid & bus.out_ready & ~req;

  // The head register is only overwritten by a new head, so after the last
  // pop it keeps showing the entry that just left.
  assign bus.out_pc     = head_q.pc;
  assign bus.out_bd     = head_q.bd;
  assign bus.out_exc    = head_q.exc;
  assign bus.out_tnew   = head_q.tnew;
  assign bus.out_data   = head_q.data;
  assign bus.out_bubble = head_q.bubble;

  // Shape the offered entry: stalled entries become bubbles, live entries
  // have Tnew counted down by one with saturation at zero.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    in_entry     = '0;
    in_entry.pc  = bus.in_pc;
    in_entry.bd  = bus.in_bd;
    in_entry.exc = bus.in_exc;
    if (kill) begin
      in_entry.bubble = 1'b1;
    end else begin
      in_entry.data   = bus.in_data;
      in_entry.tnew   = (bus.in_tnew != '0) ? bus.in_tnew - TN_W'(1) : '0;
      in_entry.bubble = 1'b0;
    end
  end

  // Next-state of the buffer: flush wins, otherwise apply push/pop.
  always_comb begin
    head_d = head_q;
    skid_d = skid_q;
    occ_d  = occ_q;
    if (req) begin
      head_d = bubble_at(EXC_PC);
      occ_d  = 2'd1;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) begin
            head_d = in_entry;
          end else begin
            skid_d = in_entry;
          end
          occ_d = occ_q + 2'd1;
        end
        2'b01: begin
          if (occ_q == 2'd2) begin
            head_d = skid_q;
          end
          occ_d = occ_q - 2'd1;
        end
        // Both only possible at occupancy 1: the new entry replaces the head.
        2'b11:   head_d = in_entry;
        default: ;
      endcase
    end
  end

  // State registers with synchronous active-low reset to the reset bubble.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments so all
    // registers update together from pre-edge values.
    if (!reset) begin
      head_q <= bubble_at(RESET_PC);
      // NOTE: the skid slot is reset too even though occupancy masks it, so
      // nothing downstream can ever pick up an X from an unwritten slot.
      skid_q <= '0;
      occ_q  <= 2'd1;
    end else begin
      head_q <= head_d;
      skid_q <= skid_d;
      occ_q  <= occ_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed test of pipe_stage_reg: reset, streaming, backpressure, kill,
// exception flush and reset-over-req priority.
module tb_pipe_stage_reg;

  logic       clk = 1'b0;
  logic       reset;
  logic       req;
  logic       kill;
  logic [1:0] occupancy;

  int errors = 0;
  int checks = 0;

  pipe_stage_reg_if bus ();

  pipe_stage_reg dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .kill      (kill),
    .bus       (bus.slave),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  // Compare one observed value with its hand-computed expectation.
  task automatic check(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled off-edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] pc, input logic bd,
                       input logic [4:0] exc, input logic [1:0] tn,
                       input logic [255:0] d);
    bus.in_valid = v;
    bus.in_pc    = pc;
    bus.in_bd    = bd;
    bus.in_exc   = exc;
    bus.in_tnew  = tn;
    bus.in_data  = d;
  endtask

  initial begin
    reset = 1'b0;
    req   = 1'b0;
    kill  = 1'b0;
    bus.out_ready = 1'b0;
    offer(1'b0, 32'h0, 1'b0, 5'd0, 2'd0, '0);

    // Reset held for two cycles, then released
    tick();
    tick();
    reset = 1'b1;
    check("rst_pc",     bus.out_pc,     32'h3000);
    check("rst_bubble", bus.out_bubble, 1'b1);
    check("rst_valid",  bus.out_valid,  1'b1);
    check("rst_occ",    occupancy,      2'd1);
    check("rst_data",   bus.out_data,   '0);
    check("rst_ready",  bus.in_ready,   1'b1);

    // Streaming with out_ready high
    bus.out_ready = 1'b1;
    offer(1'b1, 32'h3004, 1'b0, 5'd0, 2'd2, 256'h1234);
    tick();
    check("str1_pc",     bus.out_pc,     32'h3004);
    check("str1_tnew",   bus.out_tnew,   2'd1);
    check("str1_bubble", bus.out_bubble, 1'b0);
    check("str1_occ",    occupancy,      2'd1);
    offer(1'b1, 32'h3008, 1'b1, 5'd3, 2'd0, 256'hABCD);
    tick();
    check("str2_pc",   bus.out_pc,   32'h3008);
    check("str2_tnew", bus.out_tnew, 2'd0);
    check("str2_data", bus.out_data, 256'hABCD);
    check("str2_bd",   bus.out_bd,   1'b1);
    check("str2_exc",  bus.out_exc,  5'd3);
    check("str2_occ",  occupancy,    2'd1);
    offer(1'b0, 32'h0, 1'b0, 5'd0, 2'd0, '0);
    tick();
    check("drain_occ",   occupancy,     2'd0);
    check("drain_valid", bus.out_valid, 1'b0);
    check("hold_pc",     bus.out_pc,    32'h3008);
    check("hold_data",   bus.out_data,  256'hABCD);

    // Backpressure: three offers, only two accepted
    bus.out_ready = 1'b0;
    offer(1'b1, 32'h3020, 1'b0, 5'd0, 2'd3, 256'h20);
    tick();
    check("bp1_occ",   occupancy,    2'd1);
    check("bp1_ready", bus.in_ready, 1'b1);
    check("bp1_tnew",  bus.out_tnew, 2'd2);
    offer(1'b1, 32'h3024, 1'b0, 5'd0, 2'd1, 256'h24);
    tick();
    check("bp2_occ",   occupancy,    2'd2);
    check("bp2_ready", bus.in_ready, 1'b0);
    offer(1'b1, 32'h3028, 1'b0, 5'd0, 2'd1, 256'h28);
    tick();
    check("bp3_occ", occupancy,  2'd2);
    check("bp3_pc",  bus.out_pc, 32'h3020);
    offer(1'b0, 32'h0, 1'b0, 5'd0, 2'd0, '0);
    bus.out_ready = 1'b1;
    tick();
    check("bp_pop1_pc",    bus.out_pc,   32'h3024);
    check("bp_pop1_tnew",  bus.out_tnew, 2'd0);
    check("bp_pop1_data",  bus.out_data, 256'h24);
    check("bp_pop1_occ",   occupancy,    2'd1);
    check("bp_pop1_ready", bus.in_ready, 1'b1);
    tick();
    check("bp_pop2_occ", occupancy,  2'd0);
    check("bp_pop2_pc",  bus.out_pc, 32'h3024);

    // Kill push becomes a bubble
    bus.out_ready = 1'b0;
    kill = 1'b1;
    offer(1'b1, 32'h3010, 1'b1, 5'd4, 2'd2, '1);
    tick();
    check("kill_pc",     bus.out_pc,     32'h3010);
    check("kill_bd",     bus.out_bd,     1'b1);
    check("kill_exc",    bus.out_exc,    5'd4);
    check("kill_tnew",   bus.out_tnew,   2'd0);
    check("kill_data",   bus.out_data,   '0);
    check("kill_bubble", bus.out_bubble, 1'b1);
    check("kill_occ",    occupancy,      2'd1);

    // Fill to two entries, then flush with an input offered
    kill = 1'b0;
    offer(1'b1, 32'h3030, 1'b0, 5'd1, 2'd1, 256'h30);
    tick();
    check("fill_occ", occupancy, 2'd2);
    req = 1'b1;
    offer(1'b1, 32'h3034, 1'b0, 5'd2, 2'd1, 256'h34);
    tick();
    check("req2_occ",    occupancy,      2'd1);
    check("req2_pc",     bus.out_pc,     32'h4180);
    check("req2_bubble", bus.out_bubble, 1'b1);
    check("req2_exc",    bus.out_exc,    5'd0);
    check("req2_data",   bus.out_data,   '0);
    req = 1'b0;
    offer(1'b0, 32'h0, 1'b0, 5'd0, 2'd0, '0);
    bus.out_ready = 1'b1;
    tick();
    check("req2_after_occ", occupancy,  2'd0);
    check("req2_after_pc",  bus.out_pc, 32'h4180);

    // Flush from empty with in_ready high: offered entry still dropped
    req = 1'b1;
    offer(1'b1, 32'h3038, 1'b0, 5'd0, 2'd1, 256'h38);
    tick();
    check("req0_occ", occupancy,  2'd1);
    check("req0_pc",  bus.out_pc, 32'h4180);
    req = 1'b0;
    offer(1'b0, 32'h0, 1'b0, 5'd0, 2'd0, '0);
    tick();
    check("req0_after_occ", occupancy,  2'd0);
    check("req0_after_pc",  bus.out_pc, 32'h4180);

    // Reset wins over req in the same cycle
    reset = 1'b0;
    req   = 1'b1;
    tick();
    reset = 1'b1;
    req   = 1'b0;
    check("prio_pc",     bus.out_pc,     32'h3000);
    check("prio_occ",    occupancy,      2'd1);
    check("prio_bubble", bus.out_bubble, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameters SHALL be:
- DATA_W, default 256: opaque control/operand payload width.
- PC_W, default 32: PC width.
- TN_W, default 2: Tnew countdown width.
- EXC_W, default 5: exception code width.
- RESET_PC, default 32'h3000: PC loaded at reset.
- EXC_PC, default 32'h4180: PC loaded on exception request.
REQ-002 The module SHALL have one clock; reset is synchronous and active-low.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous reset, active-low (0 = reset).
- req  in  1  exception flush/redirect.
- kill  in  1  hazard stall; the accepted entry is converted to a bubble.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept an entry.
- in_pc  in  PC_W  entry PC.
- in_bd  in  1  branch-delay flag.
- in_exc  in  EXC_W  pending exception code.
- in_tnew  in  TN_W  cycles until the result is produced.
- in_data  in  DATA_W  payload.
- out_valid  out  1  head entry present.
- out_ready  in  1  downstream accepts the head.
- out_pc  out  PC_W  head PC.
- out_bd  out  1  head branch-delay flag.
- out_exc  out  EXC_W  head exception code.
- out_tnew  out  TN_W  head Tnew.
- out_data  out  DATA_W  head payload.
- out_bubble  out  1  head is a bubble.
- occupancy  out  2  number of stored entries, 0..2.

Function
REQ-004 Storage SHALL be a 2-entry in-order buffer (skid), each entry holding {pc, bd, exc, tnew, data, bubble}.
REQ-005 in_ready SHALL equal (occupancy < 2), driven from registered state only, with no combinational path from out_ready.
REQ-006 Push SHALL occur when in_valid & in_ready & ~req; pop SHALL occur when out_valid & out_ready & ~req.
REQ-007 out_valid SHALL equal (occupancy != 0); out_* SHALL present the head entry; when occupancy == 0, out_pc, out_bd, out_exc, out_tnew, out_data and out_bubble SHALL hold the values of the last popped entry.
REQ-008 Latency SHALL be 1 cycle: an entry pushed at edge N into an empty buffer is visible on out_* after edge N.
REQ-009 A normal push (kill = 0) SHALL store the entry as follows:
- pc, bd, exc, data: taken unchanged from the inputs.
- bubble: 0.
- tnew: in_tnew - 1 when in_tnew != 0, else 0 (saturating decrement, width TN_W).
REQ-010 A kill push (kill = 1) SHALL store the entry as follows:
- pc, bd, exc: taken from the inputs.
- data: all zeros.
- tnew: 0.
- bubble: 1.
REQ-011 kill with no push in that cycle SHALL have no effect.
REQ-012 Simultaneous push and pop SHALL apply as follows:
- occupancy 1: occupancy stays 1 and the new entry becomes the head.
- occupancy 2: push is impossible (in_ready = 0); pop only, so occupancy becomes 1 and the second entry becomes the head.
REQ-013 req = 1 SHALL take priority over push, pop and kill: both entries are discarded, and exactly one entry is loaded with pc = EXC_PC, bd = 0, exc = 0, tnew = 0, data = 0, bubble = 1; occupancy becomes 1.
REQ-014 req SHALL drop any input offered in the same cycle, even if in_valid = 1; upstream observes no handshake because the push condition excludes req.
REQ-015 Order SHALL be preserved; no entry is duplicated or lost except on req or reset.
REQ-016 occupancy SHALL never exceed 2 and SHALL never underflow.

Reset
REQ-017 When reset = 0 at a rising edge, the module SHALL load exactly one entry with pc = RESET_PC, bd = 0, exc = 0, tnew = 0, data = 0, bubble = 1, and set occupancy = 1; after that edge in_ready = 1 and out_valid = 1.
REQ-018 Reset SHALL take priority over req, kill and both handshakes, and SHALL abort any in-flight state mid-operation.
REQ-019 No output SHALL be undefined after the first reset edge.

Verification
REQ-020 Reset scenario: hold reset = 0 for 2 cycles, then release -> out_pc = 0x3000, out_bubble = 1, out_valid = 1, occupancy = 1, out_data = 0.
REQ-021 Streaming scenario: out_ready = 1, push pc = 0x3004, tnew = 2, then pc = 0x3008, tnew = 0 -> outputs 0x3004 with tnew 1, then 0x3008 with tnew 0, each one cycle after push; occupancy stays 1.
REQ-022 Backpressure scenario: out_ready = 0, push 3 consecutive entries -> third entry not accepted (in_ready = 0 after 2), occupancy = 2; raise out_ready -> entries drain in order, in_ready reasserts one cycle after the first pop.
REQ-023 Kill scenario: kill = 1 with push pc = 0x3010, bd = 1, exc = 4, tnew = 2, data = all ones -> head shows pc 0x3010, bd 1, exc 4, tnew 0, data 0, bubble 1.
REQ-024 Exception flush scenario: occupancy = 2, req = 1 together with in_valid = 1 -> next cycle occupancy = 1, out_pc = 0x4180, bubble = 1, exc = 0; the offered input is absent from all later outputs.
REQ-025 Priority scenario: reset = 0 and req = 1 in the same cycle -> out_pc = 0x3000, not 0x4180.
